// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder self-test controller and its LFSRs.
// The LFSR state is always 64 bits wide; narrower adders use its low bits.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Galois right-shift mask for x^64 + x^63 + x^61 + x^60 + 1
    localparam logic [63:0] LFSR_TAPS   = 64'hD800_0000_0000_0000;

    localparam logic [63:0] CORNER0_OP1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] CORNER0_OP2 = 64'h0000_0000_0000_0001;
    localparam logic [63:0] CORNER1_OP  = 64'h0000_0000_0000_0000;

    localparam logic [15:0] NO_FAIL     = 16'hFFFF;
    localparam logic [15:0] ERR_MAX     = 16'hFFFF;

    // An all-zero state would lock the LFSR, so it is replaced by 1.
    function automatic logic [63:0] lfsr_seed(input logic [63:0] seed);
        return (seed == 64'd0) ? 64'd1 : seed;
    endfunction

endpackage

// File: rtl/adder_bist_lfsr.sv
// 64-bit Galois LFSR operand source; loads its seed on request and steps when told.
// Only the low WIDTH bits are presented to the controller.
module adder_bist_lfsr
    import adder_bist_pkg::*;
#(
    parameter int          WIDTH = 64,
    parameter logic [63:0] SEED  = 64'h0123_4567_89AB_CDEF,
    parameter logic [63:0] TAPS  = LFSR_TAPS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             advance_i,
    output logic [WIDTH-1:0] state_o
);

    localparam logic [63:0] SEED_NZ = lfsr_seed(SEED);

    logic [63:0] state_q;
    logic [63:0] state_d;

    // NOTE: every path assigns state_d from a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = SEED_NZ;
        end else if (advance_i) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : 64'd0);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= SEED_NZ;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q[WIDTH-1:0];

endmodule

// File: rtl/adder_bist_ctrl.sv
// Self-test controller for the 64-bit adder family: issues corner and LFSR operand
// pairs, compares sum/carry against a reference after LATENCY cycles, reports status.
module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int          WIDTH       = 64,
    parameter int          LATENCY     = 1,
    parameter int          NUM_VECTORS = 256,
    parameter logic [63:0] SEED        = 64'h0123_4567_89AB_CDEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] sum,
    input  logic             crout,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      fail_index
);

    localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] LAST_DRAIN = 16'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]  last1_q, last2_q;
    logic [15:0]       err_q, fail_q;

    logic              run_start;
    logic              lfsr_adv;
    logic [WIDTH-1:0]  lfsr1, lfsr2;
    logic [WIDTH-1:0]  vec1, vec2;

    logic              push_vld;
    logic [WIDTH:0]    push_exp;
    logic              cmp_vld;
    logic [WIDTH:0]    cmp_exp;
    logic [15:0]       cmp_idx;
    logic              mismatch;

    // start is only honoured when no run is in flight
    assign run_start = start && ((state_q == IDLE) || (state_q == DONE));
    assign lfsr_adv  = (state_q == RUN) && (cnt_q >= 16'd2);

    adder_bist_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr1 (
        .clock     (clock),
        .reset     (reset),
        .load_i    (run_start),
        .advance_i (lfsr_adv),
        .state_o   (lfsr1)
    );

    adder_bist_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (~SEED),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr2 (
        .clock     (clock),
        .reset     (reset),
        .load_i    (run_start),
        .advance_i (lfsr_adv),
        .state_o   (lfsr2)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST_IDX) state_d = (LATENCY == 0) ? DONE : DRAIN;
            DRAIN:   if (cnt_q == LAST_DRAIN) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        op1  = '0;
        op2  = '0;
        case (state_q)
            RUN: begin
                busy = 1'b1;
                op1  = vec1;
                op2  = vec2;
            end
            DRAIN: begin
                busy = 1'b1;
                op1  = last1_q;
                op2  = last2_q;
            end
            DONE: begin
                done = 1'b1;
                op1  = last1_q;
                op2  = last2_q;
            end
            default: ;
        endcase
        pass = done && (err_q == 16'd0);
    end

    always_comb begin
        case (cnt_q)
            16'd0: begin
                vec1 = CORNER0_OP1[WIDTH-1:0];
                vec2 = CORNER0_OP2[WIDTH-1:0];
            end
            16'd1: begin
                vec1 = CORNER1_OP[WIDTH-1:0];
                vec2 = CORNER1_OP[WIDTH-1:0];
            end
            default: begin
                vec1 = lfsr1;
                vec2 = lfsr2;
            end
        endcase
    end

    // The counter restarts on every state change: vector index in RUN, drain cycles in DRAIN.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = 16'd0;
        end else if ((state_q == RUN) || (state_q == DRAIN)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q   <= 16'd0;
            last1_q <= '0;
            last2_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (state_q == RUN) begin
                last1_q <= vec1;
                last2_q <= vec2;
            end
        end
    end

    assign push_vld = (state_q == RUN);
    assign push_exp = {1'b0, vec1} + {1'b0, vec2};

    if (LATENCY == 0) begin : g_nodelay
        assign cmp_vld = push_vld;
        assign cmp_exp = push_exp;
        assign cmp_idx = cnt_q;
    end else begin : g_delay
        logic [LATENCY-1:0] vld_q;
        logic [WIDTH:0]     exp_q [LATENCY];
        logic [15:0]        idx_q [LATENCY];

        always_ff @(posedge clock) begin
            if (!reset || run_start) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= push_vld;
                for (int i = 1; i < LATENCY; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        // NOTE: the payload array is left unreset; the valid bits alone decide whether a slot is used.
        always_ff @(posedge clock) begin
            exp_q[0] <= push_exp;
            idx_q[0] <= cnt_q;
            for (int i = 1; i < LATENCY; i++) begin
                exp_q[i] <= exp_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end

        assign cmp_vld = vld_q[LATENCY-1];
        assign cmp_exp = exp_q[LATENCY-1];
        assign cmp_idx = idx_q[LATENCY-1];
    end

    assign mismatch = cmp_vld && ({crout, sum} != cmp_exp);

    // Compares land in the last RUN/DRAIN cycle at the latest, so status is final when done rises.
    always_ff @(posedge clock) begin
        if (!reset || run_start) begin
            err_q  <= 16'd0;
            fail_q <= NO_FAIL;
        end else if (mismatch) begin
            if (err_q != ERR_MAX) begin
                err_q <= err_q + 16'd1;
            end
            if (fail_q == NO_FAIL) begin
                fail_q <= cmp_idx;
            end
        end
    end

    assign err_count  = err_q;
    assign fail_index = fail_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Directed bench for adder_bist_ctrl: ideal, faulty, pipelined and saturating adder
// models around four controller instances, with an operand scoreboard.
module tb_adder_bist_ctrl;

    localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
    localparam int          NV   = 8;
    localparam int          NSAT = 65535;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    vec_t exp_q[$];
    vec_t model[NV];

    // main instance: LATENCY=1, registered adder with optional sum[5] stuck-at-0
    logic        start_m = 1'b0, fault_m = 1'b0;
    logic [63:0] op1_m, op2_m, sum_m;
    logic        crout_m, busy_m, done_m, pass_m;
    logic [15:0] err_m, fidx_m;
    logic [64:0] add_m;
    assign add_m = {1'b0, op1_m} + {1'b0, op2_m};
    always @(posedge clk) begin
        sum_m   <= fault_m ? (add_m[63:0] & ~64'h20) : add_m[63:0];
        crout_m <= add_m[64];
    end

    adder_bist_ctrl #(.WIDTH(64), .LATENCY(1), .NUM_VECTORS(NV), .SEED(SEED)) u_main (
        .clock(clk), .reset(rst_n), .start(start_m), .sum(sum_m), .crout(crout_m),
        .op1(op1_m), .op2(op2_m), .busy(busy_m), .done(done_m), .pass(pass_m),
        .err_count(err_m), .fail_index(fidx_m)
    );

    // LATENCY=0 instance with a combinational adder
    logic        start_0 = 1'b0;
    logic [63:0] op1_0, op2_0;
    logic        busy_0, done_0, pass_0;
    logic [15:0] err_0, fidx_0;
    logic [64:0] add_0;
    assign add_0 = {1'b0, op1_0} + {1'b0, op2_0};

    adder_bist_ctrl #(.WIDTH(64), .LATENCY(0), .NUM_VECTORS(NV), .SEED(SEED)) u_l0 (
        .clock(clk), .reset(rst_n), .start(start_0), .sum(add_0[63:0]), .crout(add_0[64]),
        .op1(op1_0), .op2(op2_0), .busy(busy_0), .done(done_0), .pass(pass_0),
        .err_count(err_0), .fail_index(fidx_0)
    );

    // LATENCY=3 instance; the adder pipeline can be shortened to two stages
    logic        start_3 = 1'b0, two_3 = 1'b0;
    logic [63:0] op1_3, op2_3;
    logic        busy_3, done_3, pass_3;
    logic [15:0] err_3, fidx_3;
    logic [64:0] p1_3, p2_3, p3_3, tap_3;
    always @(posedge clk) begin
        p1_3 <= {1'b0, op1_3} + {1'b0, op2_3};
        p2_3 <= p1_3;
        p3_3 <= p2_3;
    end
    assign tap_3 = two_3 ? p2_3 : p3_3;

    adder_bist_ctrl #(.WIDTH(64), .LATENCY(3), .NUM_VECTORS(NV), .SEED(SEED)) u_l3 (
        .clock(clk), .reset(rst_n), .start(start_3), .sum(tap_3[63:0]), .crout(tap_3[64]),
        .op1(op1_3), .op2(op2_3), .busy(busy_3), .done(done_3), .pass(pass_3),
        .err_count(err_3), .fail_index(fidx_3)
    );

    // saturation instance: registered adder that always returns an inverted sum
    logic        start_s = 1'b0;
    logic [63:0] op1_s, op2_s, sum_s;
    logic        crout_s, busy_s, done_s, pass_s;
    logic [15:0] err_s, fidx_s;
    logic [64:0] add_s;
    assign add_s = {1'b0, op1_s} + {1'b0, op2_s};
    always @(posedge clk) begin
        sum_s   <= ~add_s[63:0];
        crout_s <= add_s[64];
    end

    adder_bist_ctrl #(.WIDTH(64), .LATENCY(1), .NUM_VECTORS(NSAT), .SEED(SEED)) u_sat (
        .clock(clk), .reset(rst_n), .start(start_s), .sum(sum_s), .crout(crout_s),
        .op1(op1_s), .op2(op2_s), .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_count(err_s), .fail_index(fidx_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 64'(busy_m), 64'd0);
        check({tag, "_done"}, 64'(done_m), 64'd0);
        check({tag, "_pass"}, 64'(pass_m), 64'd0);
        check({tag, "_err"},  64'(err_m),  64'd0);
        check({tag, "_fidx"}, 64'(fidx_m), 64'hFFFF);
        check({tag, "_op1"},  op1_m, 64'd0);
        check({tag, "_op2"},  op2_m, 64'd0);
    endtask

    // Pulses start, scoreboards every issued operand pair and measures busy length.
    task automatic run_main(input string tag, input int inj_a, input int inj_b);
        vec_t v;
        int   len;
        exp_q.delete();
        foreach (model[k]) exp_q.push_back(model[k]);
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        check({tag, "_start_done"}, 64'(done_m), 64'd0);
        check({tag, "_start_err"},  64'(err_m),  64'd0);
        len = 0;
        while (busy_m && len < 40) begin
            start_m = (len == inj_a) || (len == inj_b);
            if (exp_q.size() > 0) begin
                v = exp_q.pop_front();
                check($sformatf("%s_op1_k%0d", tag, len), op1_m, v.a);
                check($sformatf("%s_op2_k%0d", tag, len), op2_m, v.b);
            end
            if (len == 1 && !fault_m) begin
                check({tag, "_v0_sum"},   sum_m, 64'd0);
                check({tag, "_v0_crout"}, 64'(crout_m), 64'd1);
            end
            len++;
            tick();
        end
        start_m = 1'b0;
        check({tag, "_busy_len"}, 64'(len), 64'(NV + 1));
        check({tag, "_done"}, 64'(done_m), 64'd1);
    endtask

    initial begin
        logic [63:0] s1, s2, s;
        int          err_exp, fidx_exp, n;

        s1 = SEED;
        s2 = ~SEED;
        for (int k = 0; k < NV; k++) begin
            if (k == 0) begin
                model[k] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1};
            end else if (k == 1) begin
                model[k] = '{a: 64'd0, b: 64'd0};
            end else begin
                model[k] = '{a: s1, b: s2};
                s1 = lfsr_step(s1);
                s2 = lfsr_step(s2);
            end
        end
        err_exp  = 0;
        fidx_exp = 16'hFFFF;
        for (int k = 0; k < NV; k++) begin
            s = model[k].a + model[k].b;
            if (s[5]) begin
                err_exp++;
                if (fidx_exp == 16'hFFFF) fidx_exp = k;
            end
        end

        rst_n = 1'b0;
        repeat (2) tick();
        check_reset("por");
        rst_n = 1'b1;
        tick();

        run_main("ideal", -1, -1);
        check("ideal_pass", 64'(pass_m), 64'd1);
        check("ideal_err",  64'(err_m),  64'd0);
        check("ideal_fidx", 64'(fidx_m), 64'hFFFF);

        fault_m = 1'b1;
        run_main("bit5", -1, -1);
        check("bit5_pass", 64'(pass_m), 64'd0);
        check("bit5_err",  64'(err_m),  64'(err_exp));
        check("bit5_fidx", 64'(fidx_m), 64'(fidx_exp));
        fault_m = 1'b0;

        run_main("restart", 3, 8);
        check("restart_pass", 64'(pass_m), 64'd1);
        check("restart_err",  64'(err_m),  64'd0);

        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset("midrun");
        run_main("after_reset", -1, -1);
        check("after_reset_pass", 64'(pass_m), 64'd1);

        start_0 = 1'b1;
        tick();
        start_0 = 1'b0;
        n = 0;
        while (busy_0 && n < 40) begin n++; tick(); end
        check("l0_busy_len", 64'(n), 64'(NV));
        check("l0_done", 64'(done_0), 64'd1);
        check("l0_pass", 64'(pass_0), 64'd1);
        check("l0_err",  64'(err_0),  64'd0);

        start_3 = 1'b1;
        tick();
        start_3 = 1'b0;
        n = 0;
        while (busy_3 && n < 40) begin n++; tick(); end
        check("l3_busy_len", 64'(n), 64'(NV + 3));
        check("l3_pass", 64'(pass_3), 64'd1);
        check("l3_err",  64'(err_3),  64'd0);

        two_3 = 1'b1;
        start_3 = 1'b1;
        tick();
        start_3 = 1'b0;
        n = 0;
        while (busy_3 && n < 40) begin n++; tick(); end
        check("l3short_done", 64'(done_3), 64'd1);
        check("l3short_err_nonzero", 64'(err_3 != 16'd0), 64'd1);
        check("l3short_fidx", 64'(fidx_3), 64'd0);
        check("l3short_pass", 64'(pass_3), 64'd0);

        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        n = 0;
        while (busy_s && n < 70000) begin n++; tick(); end
        check("sat_busy_len", 64'(n), 64'(NSAT + 1));
        check("sat_done", 64'(done_s), 64'd1);
        check("sat_err",  64'(err_s),  64'hFFFF);
        check("sat_fidx", 64'(fidx_s), 64'd0);
        check("sat_pass", 64'(pass_s), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
